// File: rtl/timer_pkg.sv
// Shared definitions for the periodic-event scheduler: selector width,
// arbiter states and the power-of-two terminal-count helper.
package timer_pkg;

  localparam int SEL_W = 3;
  localparam int TC_W  = 10;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_e;

  // Terminal count 2^(sel+3)-1; the 11-bit intermediate keeps 1023 exact.
  function automatic logic [TC_W-1:0] tc_of(input logic [SEL_W-1:0] sel);
    logic [TC_W:0] pow;
    logic [TC_W:0] tc_full;
    pow = '0;
    pow[{1'b0, sel} + 4'd3] = 1'b1;
    tc_full = pow - (TC_W+1)'(1);
    return tc_full[TC_W-1:0];
  endfunction

endpackage

// File: rtl/timer_chan.sv
// One period counter with its selector register; flags a single-cycle
// expiry when the enabled count reaches the selected terminal count.
module timer_chan
  import timer_pkg::*;
#(
  parameter int CW = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en_i,
  input  logic             wr_i,
  input  logic [SEL_W-1:0] sel_i,
  output logic             expire_o
);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    tc;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             at_tc;

  always_comb begin
    tc    = CW'(tc_of(sel_q));
    at_tc = (cnt_q == tc);
    sel_d = wr_i ? sel_i : sel_q;
    // A configuration write restarts the period and swallows any expiry.
    expire_o = en_i && !wr_i && at_tc;
    if (wr_i || !en_i || at_tc) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      sel_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      sel_q <= sel_d;
    end
  end

endmodule

// File: rtl/timer_irq_sched.sv
// NCH periodic timers whose expiries are latched as pending events and
// handed one at a time to a single consumer by a round-robin arbiter.
module timer_irq_sched
  import timer_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = 10,
  parameter int IDW = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NCH-1:0]   en,
  input  logic             cfg_we,
  input  logic [IDW-1:0]   cfg_ch,
  input  logic [SEL_W-1:0] cfg_sel,
  output logic             irq_valid,
  output logic [IDW-1:0]   irq_id,
  input  logic             irq_ack,
  output logic [NCH-1:0]   pending,
  output logic [NCH-1:0]   overrun
);

  state_e          state_q, state_d;
  logic            valid_q, valid_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [IDW-1:0]  rr_q, rr_d;
  logic [IDW-1:0]  pick;
  logic            found;
  int              idx;
  logic            ack_fire;
  logic [NCH-1:0]  expire, wr_sel, clr;
  logic [NCH-1:0]  pending_q, pending_d;
  logic [NCH-1:0]  overrun_q, overrun_d;

  assign ack_fire = (state_q == PRESENT) && irq_ack;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      assign wr_sel[gi] = cfg_we && (cfg_ch == IDW'(gi));
      assign clr[gi]    = ack_fire && (id_q == IDW'(gi));

      timer_chan #(.CW(CW)) u_chan (
        .clock    (clock),
        .reset    (reset),
        .en_i     (en[gi]),
        .wr_i     (wr_sel[gi]),
        .sel_i    (cfg_sel),
        .expire_o (expire[gi])
      );

      // A fresh expiry wins over the ack-clear, so no event is lost there.
      assign pending_d[gi] = expire[gi] | (pending_q[gi] & ~clr[gi]);
      assign overrun_d[gi] = wr_sel[gi] ? 1'b0
                           : (overrun_q[gi] | (expire[gi] & pending_q[gi] & ~clr[gi]));
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    id_d    = id_q;
    rr_d    = rr_q;
    found   = 1'b0;
    pick    = '0;
    idx     = 0;
    for (int k = 0; k < NCH; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (!found && pending_q[idx]) begin
        found = 1'b1;
        pick  = IDW'(idx);
      end
    end
    case (state_q)
      IDLE: begin
        if (found) begin
          valid_d = 1'b1;
          id_d    = pick;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (irq_ack) begin
          valid_d = 1'b0;
          state_d = IDLE;
          rr_d    = (id_q == IDW'(NCH-1)) ? '0 : id_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      id_q      <= '0;
      rr_q      <= '0;
      pending_q <= '0;
      overrun_q <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      id_q      <= id_d;
      rr_q      <= rr_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign irq_valid = valid_q;
  assign irq_id    = id_q;
  assign pending   = pending_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_timer_irq_sched.sv
// Directed scenarios plus a random run, all compared every cycle against a
// behavioural model built from enabled-cycle counts and a modulo scan.
module tb_timer_irq_sched;

  localparam int NCH = 4;
  localparam int CW  = 10;
  localparam int IDW = 2;

  logic             clock = 1'b0;
  logic             reset;
  logic [NCH-1:0]   en;
  logic             cfg_we;
  logic [IDW-1:0]   cfg_ch;
  logic [2:0]       cfg_sel;
  logic             irq_ack;
  logic             irq_valid;
  logic [IDW-1:0]   irq_id;
  logic [NCH-1:0]   pending;
  logic [NCH-1:0]   overrun;

  timer_irq_sched #(.NCH(NCH), .CW(CW), .IDW(IDW)) dut (
    .clock     (clock),
    .reset     (reset),
    .en        (en),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_sel   (cfg_sel),
    .irq_valid (irq_valid),
    .irq_id    (irq_id),
    .irq_ack   (irq_ack),
    .pending   (pending),
    .overrun   (overrun)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Model: enabled cycles since last restart, selector, event flags, arbiter.
  int           m_cnt [NCH];
  int           m_sel [NCH];
  bit [NCH-1:0] m_pend;
  bit [NCH-1:0] m_ovr;
  bit           m_valid;
  int           m_id;
  int           m_rr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    if (obs !== want) begin
      n_errors++;
      $display("FAIL %s t=%0t got %0h want %0h", tag, $time, obs, want);
    end
  endtask

  function automatic int period(input int s);
    return 1 << (s + 3);
  endfunction

  function automatic bit at_end(input int ch);
    return (m_cnt[ch] % period(m_sel[ch])) == period(m_sel[ch]) - 1;
  endfunction

  task automatic model_tick();
    bit [NCH-1:0] ex, cl, wr;
    bit [NCH-1:0] old_pend;
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        m_cnt[i] = 0;
        m_sel[i] = 0;
      end
      m_pend = '0; m_ovr = '0; m_valid = 0; m_id = 0; m_rr = 0;
      return;
    end
    old_pend = m_pend;
    for (int i = 0; i < NCH; i++) begin
      wr[i] = cfg_we && (int'(cfg_ch) == i);
      ex[i] = en[i] && !wr[i] && at_end(i);
      cl[i] = m_valid && irq_ack && (m_id == i);
    end
    if (m_valid) begin
      if (irq_ack) begin
        $display("event ch=%0d accepted at cycle %0d", m_id, cyc);
        m_valid = 0;
        m_rr = (m_id + 1) % NCH;
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (!m_valid && old_pend[(m_rr + k) % NCH]) begin
          m_valid = 1;
          m_id = (m_rr + k) % NCH;
        end
      end
    end
    for (int i = 0; i < NCH; i++) begin
      m_pend[i] = ex[i] || (old_pend[i] && !cl[i]);
      if (wr[i]) m_ovr[i] = 0;
      else if (ex[i] && old_pend[i] && !cl[i]) m_ovr[i] = 1;
      if (wr[i]) begin
        m_cnt[i] = 0;
        m_sel[i] = int'(cfg_sel);
      end else if (!en[i]) begin
        m_cnt[i] = 0;
      end else begin
        m_cnt[i] = m_cnt[i] + 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_tick();
    #1;
    cyc++;
    chk("valid", irq_valid, m_valid);
    chk("id", irq_id, m_id);
    chk("pending", pending, m_pend);
    chk("overrun", overrun, m_ovr);
  endtask

  task automatic do_reset();
    reset = 1'b1; en = '0; cfg_we = 0; irq_ack = 0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int limit);
    int n = 0;
    while (!irq_valid && n < limit) begin
      step();
      n++;
    end
    if (!irq_valid) chk(tag, irq_valid, 1);
  endtask

  // Expected timing from a clean reset with only channel 0 enabled at sel 0.
  task automatic s1_timing(input string tag);
    int n;
    en = 4'b0001;
    for (int s = 1; s <= 9; s++) begin
      step();
      if (s == 7) chk({tag, "_pend_early"}, pending[0], 0);
      if (s == 8) begin
        chk({tag, "_pend8"}, pending[0], 1);
        chk({tag, "_valid8"}, irq_valid, 0);
      end
    end
    chk({tag, "_valid9"}, irq_valid, 1);
    chk({tag, "_id9"}, irq_id, 0);
    irq_ack = 1; step(); irq_ack = 0;
    n = 1;
    while (!irq_valid && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_gap"}, n, 8);
    irq_ack = 1; step(); irq_ack = 0;
  endtask

  initial begin
    int n;
    reset = 1'b1; en = '0; cfg_we = 0; cfg_ch = '0; cfg_sel = '0; irq_ack = 0;
    for (int i = 0; i < NCH; i++) begin
      m_cnt[i] = 0;
      m_sel[i] = 0;
    end
    m_pend = '0; m_ovr = '0; m_valid = 0; m_id = 0; m_rr = 0;

    // Reset state and basic latency.
    do_reset();
    chk("rst_valid", irq_valid, 0);
    chk("rst_pending", pending, 0);
    chk("rst_overrun", overrun, 0);
    s1_timing("s1");

    // Longest period with the consumer stalled: overrun, then cleared by a write.
    do_reset();
    cfg_we = 1; cfg_ch = 0; cfg_sel = 3'd7; en = 4'b0001;
    step();
    cfg_we = 0;
    for (int s = 0; s < 2100; s++) step();
    chk("s2_valid", irq_valid, 1);
    chk("s2_id", irq_id, 0);
    chk("s2_ovr", overrun[0], 1);
    cfg_we = 1; cfg_ch = 0; cfg_sel = 3'd7;
    step();
    cfg_we = 0;
    chk("s2_ovr_clr", overrun[0], 0);
    irq_ack = 1; step(); irq_ack = 0;

    // All channels in lockstep: strict rotation.
    do_reset();
    en = 4'b1111;
    for (int g = 0; g < 12; g++) begin
      wait_valid("s3_timeout", 50);
      chk("s3_order", irq_id, g % NCH);
      irq_ack = 1; step(); irq_ack = 0;
      chk("s3_gap", irq_valid, 0);
    end

    // Configuration write landing exactly on the terminal count.
    do_reset();
    en = 4'b0010;
    n = 0;
    while (!at_end(1) && n < 20) begin
      step();
      n++;
    end
    cfg_we = 1; cfg_ch = 1; cfg_sel = 3'd2;
    step();
    cfg_we = 0;
    chk("s4_no_exp", pending[1], 0);
    n = 1;
    while (!pending[1] && n < 100) begin
      step();
      n++;
    end
    chk("s4_gap", n, 33);

    // Ack coinciding with a new expiry of the same channel.
    do_reset();
    en = 4'b0100;
    wait_valid("s5_timeout", 20);
    chk("s5_id", irq_id, 2);
    n = 0;
    while (!at_end(2) && n < 20) begin
      step();
      n++;
    end
    irq_ack = 1; step(); irq_ack = 0;
    chk("s5_pend", pending[2], 1);
    chk("s5_ovr", overrun[2], 0);
    wait_valid("s5_timeout2", 10);
    chk("s5_re_id", irq_id, 2);
    irq_ack = 1; step(); irq_ack = 0;

    // Reset in the middle of a handshake.
    do_reset();
    en = 4'b1111;
    cfg_we = 1; cfg_ch = 3; cfg_sel = 3'd1;
    step();
    cfg_we = 0;
    wait_valid("s6_timeout", 30);
    for (int s = 0; s < 3; s++) step();
    reset = 1'b1;
    step();
    chk("s6_valid", irq_valid, 0);
    chk("s6_id", irq_id, 0);
    chk("s6_pending", pending, 0);
    chk("s6_overrun", overrun, 0);
    reset = 1'b0;
    s1_timing("s6");

    // Random traffic.
    do_reset();
    en = 4'b1111;
    for (int s = 0; s < 3000; s++) begin
      if ($urandom_range(0, 31) == 0) en[$urandom_range(0, NCH-1)] ^= 1'b1;
      cfg_we  = ($urandom_range(0, 39) == 0);
      cfg_ch  = IDW'($urandom_range(0, NCH-1));
      cfg_sel = 3'($urandom_range(0, 3));
      irq_ack = ($urandom_range(0, 2) != 0);
      step();
    end
    cfg_we = 0; irq_ack = 0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
